// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC result path.
// Gain constants, rounding shift, result record, FIFO fill state.
package cordic_pkg;

    localparam int CORDIC_W = 16;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_t;

    typedef struct packed {
        logic signed [CORDIC_W-1:0] angle;
        logic signed [CORDIC_W-1:0] x;
        logic signed [CORDIC_W-1:0] y;
    } cordic_result_t;

    // round(0.6072529350 * 2^(bw-1)) for the widths the core is built at
    function automatic int inv_k_q(input int bw);
        case (bw)
            8:       return 78;
            12:      return 1244;
            16:      return 19898;
            20:      return 318375;
            default: return 19898;
        endcase
    endfunction

    // arithmetic shift right by n with round-half-up
    function automatic logic signed [63:0] round_shr(
        input logic signed [63:0] value,
        input int                 n
    );
        logic signed [63:0] half;
        half = 64'sd1 <<< (n - 1);
        return (value + half) >>> n;
    endfunction

endpackage

// File: rtl/cordic_result_sink_if.sv
// Consumer-side valid/ready bus of the CORDIC result sink.
// The sink drives the head entry; the consumer drives ready.
interface cordic_result_sink_if #(
    parameter int BIT_WIDTH = 16
);
    logic                        out_valid;
    logic                        out_ready;
    logic signed [BIT_WIDTH-1:0] out_angle;
    logic signed [BIT_WIDTH-1:0] out_x;
    logic signed [BIT_WIDTH-1:0] out_y;

    modport master (
        output out_valid,
        output out_angle,
        output out_x,
        output out_y,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_angle,
        input  out_x,
        input  out_y,
        output out_ready
    );
endinterface

// File: rtl/cordic_gain_scale.sv
// Removes the CORDIC gain: registered multiply by 1/K, then rounding.
// The rounded value is written straight into the sink FIFO (stage 2).
module cordic_gain_scale
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int INV_K_Q   = 19898
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic signed [BIT_WIDTH-1:0] in_angle,
    input  logic signed [BIT_WIDTH-1:0] in_x,
    input  logic signed [BIT_WIDTH-1:0] in_y,
    output logic                        out_valid,
    output logic signed [BIT_WIDTH-1:0] out_angle,
    output logic signed [BIT_WIDTH-1:0] out_x,
    output logic signed [BIT_WIDTH-1:0] out_y
);
    localparam int PW = 2 * BIT_WIDTH;
    localparam logic [BIT_WIDTH-1:0] K = BIT_WIDTH'(INV_K_Q);

    logic                        v1;
    logic signed [BIT_WIDTH-1:0] a1;
    logic signed [PW-1:0]        px;
    logic signed [PW-1:0]        py;

    // Stage 1: full-width products, angle carried alongside
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            px <= '0;
            py <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1 <= in_angle;
                px <= {{BIT_WIDTH{in_x[BIT_WIDTH-1]}}, in_x}
                    * {{BIT_WIDTH{1'b0}}, K};
                py <= {{BIT_WIDTH{in_y[BIT_WIDTH-1]}}, in_y}
                    * {{BIT_WIDTH{1'b0}}, K};
            end
        end
    end

    // 1/K < 1, so the rounded product always fits back in BIT_WIDTH
    assign out_valid = v1;
    assign out_angle = a1;
    assign out_x     = BIT_WIDTH'(round_shr(64'(px), BIT_WIDTH - 1));
    assign out_y     = BIT_WIDTH'(round_shr(64'(py), BIT_WIDTH - 1));

endmodule

// File: rtl/cordic_result_sink.sv
// CORDIC result sink: gain removal, result FIFO, upstream credits.
// Upstream may start the core only while credit_ok is high.
module cordic_result_sink
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int INV_K_Q   = inv_k_q(BIT_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         issue,
    input  logic                         in_valid,
    input  logic signed [BIT_WIDTH-1:0]  in_angle,
    input  logic signed [BIT_WIDTH-1:0]  in_x,
    input  logic signed [BIT_WIDTH-1:0]  in_y,
    output logic                         credit_ok,
    cordic_result_sink_if.master         out_if,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic signed [BIT_WIDTH-1:0] angle;
        logic signed [BIT_WIDTH-1:0] x;
        logic signed [BIT_WIDTH-1:0] y;
    } entry_t;

    entry_t                      mem [DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               outstanding;
    fifo_state_t                 fifo_state;

    logic                        s_valid;
    logic signed [BIT_WIDTH-1:0] s_angle;
    logic signed [BIT_WIDTH-1:0] s_x;
    logic signed [BIT_WIDTH-1:0] s_y;

    logic push, pop, accept, drop, grant, deny, release_credit;

    cordic_gain_scale #(
        .BIT_WIDTH (BIT_WIDTH),
        .INV_K_Q   (INV_K_Q)
    ) u_scale (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_angle  (in_angle),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (s_valid),
        .out_angle (s_angle),
        .out_x     (s_x),
        .out_y     (s_y)
    );

    // Fill state derived from occupancy
    always_comb begin
        fifo_state = FIFO_PARTIAL;
        if (count == '0)
            fifo_state = FIFO_EMPTY;
        else if (count == CW'(DEPTH))
            fifo_state = FIFO_FULL;
    end

    assign out_if.out_valid = (fifo_state != FIFO_EMPTY);
    assign out_if.out_angle = mem[rd_ptr].angle;
    assign out_if.out_x     = mem[rd_ptr].x;
    assign out_if.out_y     = mem[rd_ptr].y;

    assign pop    = out_if.out_valid & out_if.out_ready;
    assign push   = s_valid;
    // a pop frees the slot the write lands in, so full+pop still accepts
    assign accept = push & ((fifo_state != FIFO_FULL) | pop);
    assign drop   = push & ~accept;

    assign credit_ok      = (outstanding < CW'(DEPTH));
    assign grant          = issue & credit_ok;
    assign deny           = issue & ~credit_ok;
    assign release_credit = pop & (outstanding != '0);

    // Circular FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= '{angle: s_angle, x: s_x, y: s_y};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Credits: taken on granted issue, returned on pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            unique case ({grant, release_credit})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky error on dropped result or issue without credit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= 1'b0;
        else if (drop | deny)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_cordic_result_sink.sv
// Directed bench for cordic_result_sink.
// Scenario tasks with hand-computed expectations.
module tb_cordic_result_sink;
    import cordic_pkg::*;

    localparam int BW = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 issue;
    logic                 in_valid;
    logic signed [BW-1:0] in_angle;
    logic signed [BW-1:0] in_x;
    logic signed [BW-1:0] in_y;
    logic                 credit_ok;
    logic [2:0]           count;
    logic                 err;

    int checks = 0;
    int errors = 0;

    cordic_result_sink_if #(.BIT_WIDTH(BW)) bus ();

    cordic_result_sink #(
        .BIT_WIDTH (BW),
        .DEPTH     (4),
        .INV_K_Q   (19898)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .issue     (issue),
        .in_valid  (in_valid),
        .in_angle  (in_angle),
        .in_x      (in_x),
        .in_y      (in_y),
        .credit_ok (credit_ok),
        .out_if    (bus.master),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input cordic_result_t r);
        in_valid = v;
        in_angle = r.angle;
        in_x     = r.x;
        in_y     = r.y;
    endtask

    task automatic do_reset();
        issue         = 1'b0;
        in_valid      = 1'b0;
        in_angle      = '0;
        in_x          = '0;
        in_y          = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b e=%b want v=0 e=0",
                     bus.out_valid, err);
        end
        checks++;
        if (bus.out_x !== 16'sd0 || bus.out_angle !== 16'sd0) begin
            errors++;
            $display("FAIL reset_data got x=%0d a=%0d want 0 0",
                     bus.out_x, bus.out_angle);
        end
        checks++;
        if (credit_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_credit got %b want 1", credit_ok);
        end
    endtask

    task automatic one_result(
        input cordic_result_t r, input string tag,
        input logic signed [BW-1:0] ex, input logic signed [BW-1:0] ey
    );
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, r);
        step();
        in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early got valid=%b want 0", tag, bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL %s_valid got v=%b c=%0d want v=1 c=1",
                     tag, bus.out_valid, count);
        end
        checks++;
        if (bus.out_x !== ex || bus.out_y !== ey || bus.out_angle !== r.angle) begin
            errors++;
            $display("FAIL %s_data got x=%0d y=%0d a=%0d want x=%0d y=%0d a=%0d",
                     tag, bus.out_x, bus.out_y, bus.out_angle, ex, ey, r.angle);
        end
        step();
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain got c=%0d v=%b want c=0 v=0",
                     tag, count, bus.out_valid);
        end
    endtask

    task automatic test_scale();
        one_result('{angle: 16'sd12868, x: 16'sd16384, y: 16'sd0},
                   "scale", 16'sd9949, 16'sd0);
    endtask

    task automatic test_rounding();
        one_result('{angle: -16'sd5, x: -16'sd32768, y: 16'sd32767},
                   "round", -16'sd19898, 16'sd19897);
    endtask

    task automatic test_credit();
        do_reset();
        checks++;
        if (credit_ok !== 1'b1) begin
            errors++;
            $display("FAIL credit_start got %b want 1", credit_ok);
        end
        issue = 1'b1;
        repeat (3) step();
        checks++;
        if (credit_ok !== 1'b1) begin
            errors++;
            $display("FAIL credit_three got %b want 1", credit_ok);
        end
        step();
        checks++;
        if (credit_ok !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL credit_four got ok=%b e=%b want ok=0 e=0",
                     credit_ok, err);
        end
        step();
        issue = 1'b0;
        checks++;
        if (err !== 1'b1 || credit_ok !== 1'b0) begin
            errors++;
            $display("FAIL credit_over got e=%b ok=%b want e=1 ok=0",
                     err, credit_ok);
        end
        step();
        checks++;
        if (credit_ok !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL credit_hold got ok=%b e=%b want ok=0 e=1",
                     credit_ok, err);
        end
    endtask

    task automatic test_back_to_back();
        cordic_result_t r;
        do_reset();
        for (int cyc = 0; cyc < 16; cyc++) begin
            r = '{angle: 16'(cyc + 1), x: 16'sd16384, y: 16'sd8192};
            drive(cyc <= 12, r);
            bus.out_ready = (cyc >= 5);
            if (cyc >= 5 && cyc <= 13) begin
                checks++;
                if (count !== 3'd4 || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_count cyc=%0d got c=%0d v=%b want c=4 v=1",
                             cyc, count, bus.out_valid);
                end
                checks++;
                if (bus.out_angle !== 16'(cyc - 4) || bus.out_x !== 16'sd9949
                    || bus.out_y !== 16'sd4975) begin
                    errors++;
                    $display("FAIL b2b_order cyc=%0d got a=%0d x=%0d y=%0d want a=%0d x=9949 y=4975",
                             cyc, bus.out_angle, bus.out_x, bus.out_y, cyc - 4);
                end
            end
            step();
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err got %b want 0", err);
        end
    endtask

    task automatic test_overflow();
        cordic_result_t r;
        do_reset();
        for (int cyc = 0; cyc < 5; cyc++) begin
            r = '{angle: 16'(21 + cyc), x: 16'sd16384, y: 16'sd0};
            drive(1'b1, r);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got c=%0d e=%b want c=4 e=0", count, err);
        end
        step();
        checks++;
        if (err !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_drop got e=%b c=%0d want e=1 c=4", err, count);
        end
        checks++;
        if (bus.out_angle !== 16'sd21 || bus.out_x !== 16'sd9949) begin
            errors++;
            $display("FAIL ovf_head got a=%0d x=%0d want a=21 x=9949",
                     bus.out_angle, bus.out_x);
        end
    endtask

    task automatic test_async_reset();
        cordic_result_t r;
        do_reset();
        for (int cyc = 0; cyc < 4; cyc++) begin
            r = '{angle: 16'(31 + cyc), x: 16'sd16384, y: 16'sd0};
            drive(1'b1, r);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL arst_pre got c=%0d want 3", count);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_angle !== 16'sd0) begin
            errors++;
            $display("FAIL arst_now got c=%0d v=%b a=%0d want 0 0 0",
                     count, bus.out_valid, bus.out_angle);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || credit_ok !== 1'b1
            || err !== 1'b0) begin
            errors++;
            $display("FAIL arst_post got c=%0d v=%b ok=%b e=%b want 0 0 1 0",
                     count, bus.out_valid, credit_ok, err);
        end
    endtask

    initial begin
        test_reset();
        test_scale();
        test_rounding();
        test_credit();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
